// File: rtl/pc_prot_pkg.sv
// Shared types for the protected-PC recovery logic.
// Latency: n/a (types only).
// Backpressure: n/a.
package pc_prot_pkg;

    localparam int PC_W = 32;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        RELOAD = 3'd1,
        WAIT   = 3'd2,
        CHECK  = 3'd3,
        FATAL  = 3'd4
    } pc_rec_state_t;

endpackage

// File: rtl/pc_rec_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
// Latency: count updates the cycle after inc is sampled.
// Backpressure: none; inc is accepted every cycle.
module pc_rec_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pc_recovery_ctrl.sv
// PC double-error recovery: reload checkpoint, wait out flag latency, re-check, retry or go FATAL.
// Latency: stall rises the cycle after the error flag; clean recovery returns to RUN 3 cycles after entering RELOAD.
// Backpressure: drives stall to hold the core; err_count counter only exists when PC_RECOVERY_STATS_EN is defined.
module pc_recovery_ctrl
    import pc_prot_pkg::*;
#(
    parameter int          MAX_RETRY = 3,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [PC_W-1:0]  pc_next_core,
    input  logic             commit,
    input  logic [PC_W-1:0]  pc_corrected,
    input  logic             double_error_flag,
    output logic [PC_W-1:0]  pc_next_out,
    output logic             stall,
    output logic             recover_busy,
    output logic             fatal_error,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

    pc_rec_state_t   state_q, state_d;
    logic [PC_W-1:0] ckpt_q, ckpt_d;
    logic [3:0]      retry_q, retry_d;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= RUN;
            ckpt_q  <= RESET_PC;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            ckpt_q  <= ckpt_d;
            retry_q <= retry_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ckpt_d       = ckpt_q;
        retry_d      = retry_q;
        pc_next_out  = ckpt_q;
        stall        = 1'b1;
        recover_busy = 1'b0;
        fatal_error  = 1'b0;
        unique case (state_q)
            RUN: begin
                pc_next_out = pc_next_core;
                stall       = 1'b0;
                // An erroring cycle must never overwrite the last good checkpoint.
                if (double_error_flag) begin
                    state_d = RELOAD;
                    retry_d = 4'd1;
                end else if (commit) begin
                    ckpt_d = pc_corrected;
                end
            end
            RELOAD: begin
                recover_busy = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                recover_busy = 1'b1;
                state_d      = CHECK;
            end
            CHECK: begin
                recover_busy = 1'b1;
                if (!double_error_flag) begin
                    state_d = RUN;
                    retry_d = '0;
                end else if (retry_q < RETRY_MAX) begin
                    state_d = RELOAD;
                    retry_d = retry_q + 4'd1;
                end else begin
                    state_d = FATAL;
                end
            end
            FATAL: begin
                fatal_error = 1'b1;
            end
            default: begin
                state_d = FATAL;
            end
        endcase
    end

`ifdef PC_RECOVERY_STATS_EN
    logic err_inc;
    assign err_inc = double_error_flag && ((state_q == RUN) || (state_q == CHECK));

    pc_rec_sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rstN  (rstN),
        .inc   (err_inc),
        .count (err_count)
    );
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_pc_recovery_ctrl.sv
// Directed bench for pc_recovery_ctrl: two instances (CNT_W 8 and 2) share stimulus;
// a cycle model pushes expected outputs to a queue, popped and compared after each edge.
module tb_pc_recovery_ctrl;
    import pc_prot_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct {
        logic        stall;
        logic        busy;
        logic        fatal;
        logic [31:0] pc;
        logic [7:0]  err;
        logic [1:0]  err2;
    } exp_t;

    logic        clk;
    logic        rstN;
    logic [31:0] pc_next_core;
    logic        commit;
    logic [31:0] pc_corrected;
    logic        double_error_flag;

    logic [31:0] pc_out_a, pc_out_b;
    logic        stall_a, stall_b, busy_a, busy_b, fatal_a, fatal_b;
    logic [7:0]  err_a;
    logic [1:0]  err_b;

    int total = 0;
    int bad   = 0;

    exp_t sb[$];

    pc_rec_state_t m_state;
    logic [31:0]   m_ckpt;
    int            m_retry;
    int            m_err;

    pc_recovery_ctrl #(.MAX_RETRY(3), .RESET_PC(RST_PC), .CNT_W(8)) u_dut (
        .clk(clk), .rstN(rstN), .pc_next_core(pc_next_core), .commit(commit),
        .pc_corrected(pc_corrected), .double_error_flag(double_error_flag),
        .pc_next_out(pc_out_a), .stall(stall_a), .recover_busy(busy_a),
        .fatal_error(fatal_a), .err_count(err_a)
    );

    pc_recovery_ctrl #(.MAX_RETRY(3), .RESET_PC(RST_PC), .CNT_W(2)) u_dut2 (
        .clk(clk), .rstN(rstN), .pc_next_core(pc_next_core), .commit(commit),
        .pc_corrected(pc_corrected), .double_error_flag(double_error_flag),
        .pc_next_out(pc_out_b), .stall(stall_b), .recover_busy(busy_b),
        .fatal_error(fatal_b), .err_count(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_err8();
`ifdef PC_RECOVERY_STATS_EN
        return (m_err > 255) ? 8'hFF : 8'(m_err);
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [1:0] exp_err2();
`ifdef PC_RECOVERY_STATS_EN
        return (m_err > 3) ? 2'd3 : 2'(m_err);
`else
        return 2'd0;
`endif
    endfunction

    function automatic void model_reset();
        m_state = RUN;
        m_ckpt  = RST_PC;
        m_retry = 0;
        m_err   = 0;
    endfunction

    function automatic void model_adv(input logic cm, input logic [31:0] corr, input logic fl);
        case (m_state)
            RUN: begin
                if (fl) begin
                    m_err++;
                    m_retry = 1;
                    m_state = RELOAD;
                end else if (cm) begin
                    m_ckpt = corr;
                end
            end
            RELOAD: m_state = WAIT;
            WAIT:   m_state = CHECK;
            CHECK: begin
                if (!fl) begin
                    m_retry = 0;
                    m_state = RUN;
                end else begin
                    m_err++;
                    if (m_retry < 3) begin
                        m_retry++;
                        m_state = RELOAD;
                    end else begin
                        m_state = FATAL;
                    end
                end
            end
            default: m_state = FATAL;
        endcase
    endfunction

    task automatic check_now(input exp_t e);
        chk("pc_a",    pc_out_a, e.pc);
        chk("pc_b",    pc_out_b, e.pc);
        chk("stall_a", 32'(stall_a), 32'(e.stall));
        chk("stall_b", 32'(stall_b), 32'(e.stall));
        chk("busy_a",  32'(busy_a),  32'(e.busy));
        chk("busy_b",  32'(busy_b),  32'(e.busy));
        chk("fatal_a", 32'(fatal_a), 32'(e.fatal));
        chk("fatal_b", 32'(fatal_b), 32'(e.fatal));
        chk("err_a",   32'(err_a),   32'(e.err));
        chk("err_b",   32'(err_b),   32'(e.err2));
    endtask

    task automatic step(input logic [31:0] core, input logic cm,
                        input logic [31:0] corr, input logic fl);
        exp_t e;
        pc_next_core      = core;
        commit            = cm;
        pc_corrected      = corr;
        double_error_flag = fl;
        model_adv(cm, corr, fl);
        e.stall = (m_state != RUN);
        e.busy  = (m_state == RELOAD) || (m_state == WAIT) || (m_state == CHECK);
        e.fatal = (m_state == FATAL);
        e.pc    = (m_state == RUN) ? core : m_ckpt;
        e.err   = exp_err8();
        e.err2  = exp_err2();
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: queue empty, observed=0 expected=1");
        end else begin
            check_now(sb.pop_front());
        end
    endtask

    // One clean recovery: error in RUN, then RELOAD/WAIT/CHECK with flag low.
    task automatic recover_once(input logic [31:0] core);
        step(core, 1'b0, 32'h0, 1'b1);
        step(core, 1'b0, 32'h0, 1'b0);
        step(core, 1'b0, 32'h0, 1'b0);
        step(core, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic async_reset_check(input string tag);
        rstN = 1'b0;
        #1;
        model_reset();
        chk({tag, "_stall"}, 32'(stall_a), 32'd0);
        chk({tag, "_busy"},  32'(busy_a),  32'd0);
        chk({tag, "_fatal"}, 32'(fatal_a), 32'd0);
        chk({tag, "_err"},   32'(err_a),   32'd0);
        chk({tag, "_pc"},    pc_out_a,     pc_next_core);
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    initial begin
        pc_next_core      = 32'h0000_1000;
        commit            = 1'b0;
        pc_corrected      = 32'h0;
        double_error_flag = 1'b0;
        rstN              = 1'b1;
        #2;
        async_reset_check("rst_init");

        // Reset checkpoint value is reloaded when no commit has happened yet.
        recover_once(32'h0000_2000);
        step(32'h0000_2004, 1'b0, 32'h0, 1'b0);

        // Commits 0x10, 0x14, 0x18 then an error: reload 0x18, back to RUN in 4 cycles.
        step(32'h0000_0014, 1'b1, 32'h0000_0010, 1'b0);
        step(32'h0000_0018, 1'b1, 32'h0000_0014, 1'b0);
        step(32'h0000_001C, 1'b1, 32'h0000_0018, 1'b0);
        step(32'h0000_0020, 1'b0, 32'h0, 1'b1);
        chk("reload_0x18", pc_out_a, 32'h0000_0018);
        step(32'h0000_0020, 1'b0, 32'h0, 1'b0);
        chk("wait_0x18", pc_out_a, 32'h0000_0018);
        step(32'h0000_0020, 1'b1, 32'h0000_0777, 1'b0);
        step(32'h0000_0020, 1'b0, 32'h0, 1'b0);
        chk("run_stall_low", 32'(stall_a), 32'd0);

        // Commit and error in the same cycle: the older checkpoint survives.
        step(32'h0000_0040, 1'b1, 32'h0000_003C, 1'b0);
        step(32'h0000_0044, 1'b1, 32'h0000_0040, 1'b1);
        chk("same_cycle_ckpt", pc_out_a, 32'h0000_003C);
        step(32'h0000_0044, 1'b0, 32'h0, 1'b0);
        step(32'h0000_0044, 1'b0, 32'h0, 1'b0);
        step(32'h0000_0044, 1'b0, 32'h0, 1'b0);

        // Reset pulsed in WAIT aborts recovery.
        step(32'h0000_0050, 1'b0, 32'h0, 1'b1);
        step(32'h0000_0050, 1'b0, 32'h0, 1'b0);
        async_reset_check("rst_wait");
        step(32'h0000_0060, 1'b0, 32'h0, 1'b0);
        step(32'h0000_0064, 1'b0, 32'h0, 1'b0);

        // Five separate recoveries: narrow counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            recover_once(32'h0000_0080 + 32'(i * 4));
        end
        step(32'h0000_00A0, 1'b1, 32'h0000_009C, 1'b0);

        // Flag held high: 3 reload rounds then FATAL, which persists.
        for (int i = 0; i < 10; i++) begin
            step(32'h0000_00B0, 1'b0, 32'h0, 1'b1);
        end
        chk("fatal_after_3_retries", 32'(fatal_a), 32'd1);
        chk("fatal_hold_pc", pc_out_a, 32'h0000_009C);
        for (int i = 0; i < 22; i++) begin
            step(32'h0000_00C0 + 32'(i), (i % 2) == 0, 32'h0000_0DEA, (i % 3) == 0);
        end
        async_reset_check("rst_fatal");
        step(32'h0000_0200, 1'b0, 32'h0, 1'b0);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_recovery_ctrl.md
PC_RECOVERY_CTRL -- requirements
Module: pc_recovery_ctrl

Interface
- REQ-001: Parameter MAX_RETRY, default 3; reload attempts allowed before fatal, range 1..15.
- REQ-002: Parameter RESET_PC, default 32'h0000_0000; checkpoint value after reset.
- REQ-003: Parameter CNT_W, default 8; width of the error statistics counter.
- REQ-004: clk  input  1  single clock; all state changes on rising edge.
- REQ-005: rstN  input  1  asynchronous, active-low reset.
- REQ-006: pc_next_core  input  32  next PC proposed by core datapath.
- REQ-007: commit  input  1  current instruction retires this cycle.
- REQ-008: pc_corrected  input  32  corrected PC from protected PC register.
- REQ-009: double_error_flag  input  1  uncorrectable-error flag from protected PC register, registered at its source.
- REQ-010: pc_next_out  output  32  value driven into protected PC register nextcount.
- REQ-011: stall  output  1  core must hold its pipeline.
- REQ-012: recover_busy  output  1  recovery sequence in progress (RELOAD/WAIT/CHECK).
- REQ-013: fatal_error  output  1  recovery exhausted; sticky until reset.
- REQ-014: err_count  output  CNT_W  saturating count of detected double errors.

Function
- REQ-015: FSM states: RUN, RELOAD, WAIT, CHECK, FATAL; state held in a register.
- REQ-016: All outputs decode from registered state and counters only; no input-to-output combinational path except pc_next_out = pc_next_core in RUN.
- REQ-017: RUN: pc_next_out = pc_next_core, stall = 0, recover_busy = 0.
- REQ-018: RUN with commit = 1 and double_error_flag = 0: checkpoint <= pc_corrected.
- REQ-019: RUN with double_error_flag = 1: next state RELOAD; retry_cnt <= 1; checkpoint not updated, even if commit = 1 in the same cycle.
- REQ-020: RELOAD (1 cycle): pc_next_out = checkpoint, stall = 1; next state WAIT.
- REQ-021: WAIT (1 cycle): pc_next_out = checkpoint, stall = 1; covers the one-cycle flag latency of the PC register; next state CHECK.
- REQ-022: CHECK with double_error_flag = 0: next state RUN; retry_cnt <= 0; stall deasserts the cycle RUN is entered.
- REQ-023: CHECK with double_error_flag = 1 and retry_cnt < MAX_RETRY: next state RELOAD; retry_cnt increments.
- REQ-024: CHECK with double_error_flag = 1 and retry_cnt == MAX_RETRY: next state FATAL.
- REQ-025: FATAL: pc_next_out = checkpoint, stall = 1, fatal_error = 1; state left only by reset.
- REQ-026: commit is ignored in every state except RUN.
- REQ-027: err_count increments by 1 on every cycle where double_error_flag = 1 in RUN or CHECK; it saturates at 2^CNT_W-1 and never wraps.
- REQ-028: Worst-case recovery latency: 3*MAX_RETRY cycles from RELOAD entry to FATAL entry.

Reset
- REQ-029: rstN low asynchronously forces state = RUN, checkpoint = RESET_PC, retry_cnt = 0, err_count = 0, fatal_error = 0.
- REQ-030: Reset asserted mid-recovery aborts the sequence; the first cycle after release is RUN with stall = 0.

Configuration
- REQ-031: Macro PC_RECOVERY_STATS_EN defined: err_count counter implemented per REQ-027.
- REQ-032: Macro PC_RECOVERY_STATS_EN undefined: err_count port remains present and is tied to 0, with no counter flops; all other behaviour is identical.

Structure
- REQ-033: Shared package pc_prot_pkg holds enum pc_rec_state_t (RUN, RELOAD, WAIT, CHECK, FATAL) and the 32-bit PC width constant.
- REQ-034: One sub-module, pc_rec_sat_counter (parameterised width, increment enable, saturating), instantiated for err_count under PC_RECOVERY_STATS_EN.

Verification
- REQ-035: Commits at pc_corrected 0x10, 0x14, 0x18, then inject double_error_flag = 1 -> stall rises the next cycle; pc_next_out = 0x18 in RELOAD/WAIT; flag cleared in CHECK -> RUN; stall low 4 cycles after injection; err_count = 1.
- REQ-036: commit = 1 and double_error_flag = 1 in the same RUN cycle with pc_corrected = 0x40, prior checkpoint 0x3C -> reload value is 0x3C.
- REQ-037: MAX_RETRY = 3, flag held high -> exactly 3 RELOAD entries, then FATAL; fatal_error = 1 persists for 20 or more cycles; err_count = 4.
- REQ-038: rstN pulsed low during WAIT -> all outputs reset immediately; after release, stall = 0 and pc_next_out follows pc_next_core.
- REQ-039: CNT_W = 2 with 5 separate single-retry recoveries -> err_count saturates at 3.
- REQ-040: Build without PC_RECOVERY_STATS_EN and run the REQ-037 stimulus -> err_count = 0; FSM behaviour unchanged.
